// File: rtl/issue_sched.sv
// issue_sched: in-order issue controller between predecode and the
// add/mul execute-writeback datapath.
//
// Accepts one decoded instruction per cycle over a valid/ready handshake.
// The destination tag of every issued instruction is carried down a
// LAT-deep scoreboard that mirrors the datapath pipes. Any instruction
// whose used source matches an in-flight tag is held off, and a NOP
// bubble is presented to the datapath instead.
//
// A run is sequenced IDLE -> RUN -> DRAIN -> DONE -> IDLE. The run also
// counts accepted instructions and hazard stall cycles.
//
// Ports:
//   clock, rst        clock; asynchronous active-low reset
//   go                start-of-run request (looked at in IDLE only)
//   in_valid/in_ready instruction handshake (in_ready is combinational)
//   in_opcode         000 NOP, 001 ADD, 010 MUL, 011 ADDI, 1xx NOP-like
//   in_rs1/rs2/rd     register fields
//   in_imm            immediate field
//   in_last           final instruction of the run
//   dp_*              instruction to the datapath (all zero = bubble)
//   dp_start          datapath pipeline advance enable
//   busy              high in RUN and DRAIN
//   done              one-cycle run-complete pulse
//   issue_cnt         instructions accepted this run (saturating)
//   stall_cnt         hazard stall cycles this run (saturating)
module issue_sched #(
  parameter int LAT  = 4,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            go,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_opcode,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [11:0]     in_imm,
  input  logic            in_last,
  output logic [2:0]      dp_opcode,
  output logic [4:0]      dp_rs1,
  output logic [4:0]      dp_rs2,
  output logic [4:0]      dp_rd,
  output logic [11:0]     dp_imm,
  output logic            dp_start,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] issue_cnt,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [4:0] sb [LAT];

  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       sb_empty;
  logic       issue;
  logic [4:0] issue_tag;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // Decode and hazard check against every in-flight tag
  always_comb begin
    use_rs1  = (in_opcode == OP_ADD) || (in_opcode == OP_MUL) || (in_opcode == OP_ADDI);
    // ADDI's rs2 bits belong to the immediate, so they never cause a stall
    use_rs2  = (in_opcode == OP_ADD) || (in_opcode == OP_MUL);
    hazard   = 1'b0;
    sb_empty = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      if (use_rs1 && (in_rs1 != 5'd0) && (sb[i] == in_rs1)) hazard = 1'b1;
      if (use_rs2 && (in_rs2 != 5'd0) && (sb[i] == in_rs2)) hazard = 1'b1;
      if (sb[i] != 5'd0) sb_empty = 1'b0;
    end
  end

  assign in_ready  = (state == S_RUN) && !hazard;
  assign issue     = in_valid && in_ready;
  // Writing r0 is architecturally a no-op, so it never enters the scoreboard
  assign issue_tag = (issue && use_rs1) ? in_rd : 5'd0;

  // Datapath reads the register file in the issue cycle, hence combinational
  assign dp_opcode = issue ? in_opcode : 3'd0;
  assign dp_rs1    = issue ? in_rs1    : 5'd0;
  assign dp_rs2    = issue ? in_rs2    : 5'd0;
  assign dp_rd     = issue ? in_rd     : 5'd0;
  assign dp_imm    = issue ? in_imm    : 12'd0;

  // Run sequencer with registered status outputs
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dp_start <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            dp_start <= 1'b1;
          end
        end
        S_RUN: begin
          if (issue && in_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (sb_empty) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            dp_start <= 1'b0;
            done     <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          dp_start <= 1'b0;
        end
      endcase
    end
  end

  // Scoreboard: tags advance in lockstep with the datapath pipes
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) sb[i] <= 5'd0;
    end else if (dp_start) begin
      sb[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) sb[i] <= sb[i-1];
    end
  end

  // Run statistics, cleared when a new run starts
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else if ((state == S_IDLE) && go) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue) issue_cnt <= sat_inc(issue_cnt);
      if ((state == S_RUN) && in_valid && hazard) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_issue_sched.sv
module tb_issue_sched;

  localparam int LAT  = 4;
  localparam int CNTW = 16;
  localparam int NV   = 20;

  logic            clock = 1'b0;
  logic            rst;
  logic            go;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_opcode;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic [11:0]     in_imm;
  logic            in_last;
  logic [2:0]      dp_opcode;
  logic [4:0]      dp_rs1, dp_rs2, dp_rd;
  logic [11:0]     dp_imm;
  logic            dp_start, busy, done;
  logic [CNTW-1:0] issue_cnt, stall_cnt;

  always #5 clock = ~clock;

  issue_sched #(.LAT(LAT), .CNTW(CNTW)) dut (
    .clock(clock), .rst(rst), .go(go),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last),
    .dp_opcode(dp_opcode), .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rd(dp_rd),
    .dp_imm(dp_imm), .dp_start(dp_start), .busy(busy), .done(done),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        vld;
    logic [2:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic        last;
    logic        rdy;
    logic [2:0]  dop;
    logic [4:0]  drd;
    int          ic;
    int          sc;
  } vec_t;

  vec_t tbl [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [2:0] op,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [11:0] imm,
                              input logic last, input logic rdy,
                              input logic [2:0] dop, input logic [4:0] drd,
                              input int ic, input int sc);
    vec_t v;
    v.vld = vld; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.imm = imm; v.last = last; v.rdy = rdy; v.dop = dop; v.drd = drd;
    v.ic = ic; v.sc = sc;
    return v;
  endfunction

  task automatic drive(input logic vld, input logic [2:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [11:0] imm, input logic last);
    in_valid = vld; in_opcode = op; in_rs1 = rs1; in_rs2 = rs2;
    in_rd = rd; in_imm = imm; in_last = last;
  endtask

  initial begin
    // Run 1 rows: inputs | ready, dp_opcode, dp_rd, issue_cnt, stall_cnt
    tbl[0]  = mk(1, 3'd1, 5'd1, 5'd2, 5'd3,  12'd0, 0, 1, 3'd1, 5'd3,  0, 0);
    tbl[1]  = mk(1, 3'd1, 5'd4, 5'd5, 5'd6,  12'd0, 0, 1, 3'd1, 5'd6,  1, 0);
    tbl[2]  = mk(0, 3'd0, 5'd0, 5'd0, 5'd0,  12'd0, 0, 1, 3'd0, 5'd0,  2, 0);
    tbl[3]  = mk(0, 3'd0, 5'd0, 5'd0, 5'd0,  12'd0, 0, 1, 3'd0, 5'd0,  2, 0);
    tbl[4]  = mk(0, 3'd0, 5'd0, 5'd0, 5'd0,  12'd0, 0, 1, 3'd0, 5'd0,  2, 0);
    // RAW: producer r3, then MUL r4=r3*r3 held for LAT cycles
    tbl[5]  = mk(1, 3'd1, 5'd1, 5'd2, 5'd3,  12'd0, 0, 1, 3'd1, 5'd3,  2, 0);
    tbl[6]  = mk(1, 3'd2, 5'd3, 5'd3, 5'd4,  12'd0, 0, 0, 3'd0, 5'd0,  3, 0);
    tbl[7]  = mk(1, 3'd2, 5'd3, 5'd3, 5'd4,  12'd0, 0, 0, 3'd0, 5'd0,  3, 1);
    tbl[8]  = mk(1, 3'd2, 5'd3, 5'd3, 5'd4,  12'd0, 0, 0, 3'd0, 5'd0,  3, 2);
    tbl[9]  = mk(1, 3'd2, 5'd3, 5'd3, 5'd4,  12'd0, 0, 0, 3'd0, 5'd0,  3, 3);
    tbl[10] = mk(1, 3'd2, 5'd3, 5'd3, 5'd4,  12'd0, 0, 1, 3'd2, 5'd4,  3, 4);
    // ADDI whose rs2 bits alias an in-flight r3
    tbl[11] = mk(1, 3'd1, 5'd1, 5'd2, 5'd3,  12'd0, 0, 1, 3'd1, 5'd3,  4, 4);
    tbl[12] = mk(1, 3'd3, 5'd1, 5'd3, 5'd5,  12'd3, 0, 1, 3'd3, 5'd5,  5, 4);
    // r0 destination, then consumer of r0
    tbl[13] = mk(1, 3'd1, 5'd1, 5'd2, 5'd0,  12'd0, 0, 1, 3'd1, 5'd0,  6, 4);
    tbl[14] = mk(1, 3'd1, 5'd0, 5'd0, 5'd7,  12'd0, 0, 1, 3'd1, 5'd7,  7, 4);
    // 1xx opcode: no sources used, no tag recorded
    tbl[15] = mk(1, 3'd5, 5'd7, 5'd7, 5'd9,  12'd0, 0, 1, 3'd5, 5'd9,  8, 4);
    tbl[16] = mk(1, 3'd1, 5'd9, 5'd0, 5'd10, 12'd0, 0, 1, 3'd1, 5'd10, 9, 4);
    // rs2-only hazard on deep entry; invalid hazard cycle not counted
    tbl[17] = mk(1, 3'd1, 5'd0, 5'd7, 5'd11, 12'd0, 0, 0, 3'd0, 5'd0, 10, 4);
    tbl[18] = mk(0, 3'd1, 5'd0, 5'd7, 5'd11, 12'd0, 0, 0, 3'd0, 5'd0, 10, 5);
    tbl[19] = mk(1, 3'd1, 5'd1, 5'd2, 5'd9,  12'd0, 1, 1, 3'd1, 5'd9, 10, 5);

    rst = 1'b0;
    go  = 1'b0;
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'd0, 0);
    #2;
    chk("rst_busy",     busy,      0);
    chk("rst_done",     done,      0);
    chk("rst_dp_start", dp_start,  0);
    chk("rst_in_ready", in_ready,  0);
    chk("rst_issue",    issue_cnt, 0);
    chk("rst_stall",    stall_cnt, 0);
    chk("rst_dp_op",    dp_opcode, 0);
    @(negedge clock);
    rst = 1'b1;

    // go held high through RUN to show it is ignored outside IDLE
    @(negedge clock);
    go = 1'b1;
    for (int i = 0; i < NV; i++) begin
      logic iss;
      @(negedge clock);
      drive(tbl[i].vld, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, tbl[i].last);
      #1;
      iss = tbl[i].vld & tbl[i].rdy;
      chk($sformatf("v%0d_ready", i),    in_ready,  tbl[i].rdy);
      chk($sformatf("v%0d_dp_op", i),    dp_opcode, tbl[i].dop);
      chk($sformatf("v%0d_dp_rd", i),    dp_rd,     tbl[i].drd);
      chk($sformatf("v%0d_dp_rs1", i),   dp_rs1,    iss ? tbl[i].rs1 : 0);
      chk($sformatf("v%0d_dp_rs2", i),   dp_rs2,    iss ? tbl[i].rs2 : 0);
      chk($sformatf("v%0d_dp_imm", i),   dp_imm,    iss ? tbl[i].imm : 0);
      chk($sformatf("v%0d_issue", i),    issue_cnt, tbl[i].ic);
      chk($sformatf("v%0d_stall", i),    stall_cnt, tbl[i].sc);
      chk($sformatf("v%0d_busy", i),     busy,      1);
      chk($sformatf("v%0d_dp_start", i), dp_start,  1);
    end

    // Drain: last issued at edge t; done after edge t+LAT+1
    @(negedge clock);
    go = 1'b0;
    drive(1, 3'd1, 5'd1, 5'd2, 5'd12, 12'd0, 0);
    #1;
    chk("drain_busy",     busy,      1);
    chk("drain_ready",    in_ready,  0);
    chk("drain_dp_op",    dp_opcode, 0);
    chk("drain_dp_start", dp_start,  1);
    chk("drain_done",     done,      0);
    chk("drain_issue",    issue_cnt, 11);
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'd0, 0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("drain%0d_busy", k), busy, 1);
      chk($sformatf("drain%0d_done", k), done, 0);
    end
    @(negedge clock);
    #1;
    chk("done_pulse",    done,     1);
    chk("done_busy",     busy,     0);
    chk("done_dp_start", dp_start, 0);
    @(negedge clock);
    #1;
    chk("idle_done",     done,      0);
    chk("idle_busy",     busy,      0);
    chk("idle_dp_start", dp_start,  0);
    chk("idle_ready",    in_ready,  0);
    chk("idle_issue",    issue_cnt, 11);
    chk("idle_stall",    stall_cnt, 5);

    // Run 2: counters clear on go, then reset while r9 sits in sb[1]
    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    drive(1, 3'd1, 5'd1, 5'd2, 5'd9, 12'd0, 1);
    #1;
    chk("r2_issue_clr", issue_cnt, 0);
    chk("r2_stall_clr", stall_cnt, 0);
    chk("r2_ready",     in_ready,  1);
    chk("r2_dp_rd",     dp_rd,     9);
    @(negedge clock);
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'd0, 0);
    #1;
    chk("r2_drain_busy", busy,      1);
    chk("r2_issue",      issue_cnt, 1);
    @(posedge clock);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy",     busy,      0);
    chk("arst_done",     done,      0);
    chk("arst_dp_start", dp_start,  0);
    chk("arst_ready",    in_ready,  0);
    chk("arst_issue",    issue_cnt, 0);
    @(negedge clock);
    rst = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("arst_idle%0d_done", k), done, 0);
      chk($sformatf("arst_idle%0d_busy", k), busy, 0);
    end

    // Fresh run: dependents of the discarded r9 issue without stalling
    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    drive(1, 3'd1, 5'd9, 5'd9, 5'd10, 12'd0, 0);
    #1;
    chk("r3_ready", in_ready,  1);
    chk("r3_dp_rd", dp_rd,     10);
    chk("r3_stall", stall_cnt, 0);
    @(negedge clock);
    drive(1, 3'd2, 5'd9, 5'd10, 5'd11, 12'd0, 0);
    #1;
    chk("r3_dep_ready", in_ready,  0);
    chk("r3_dep_dp_op", dp_opcode, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
